// File: rtl/line_render_scheduler.sv
// line_render_scheduler: sequences layer0, layer1 and sprite
// rendering per line, ping-pongs line-buffer banks, counts overruns.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   line_render_start/line_idx render request and its line index
//   layer0/layer1/sprites_enabled  enables, sampled at request
//   sprite_lb_erase_start      sprite line-buffer erase begun
//   erase_done                 sprite line-buffer erase finished
//   layer0/layer1/sprite_done  renderer completion pulses
//   overrun_clear              zero the overrun counter
//   layer0/layer1/sprite_start renderer start pulses
//   render_abort               current line dropped (overrun)
//   render_line                line being rendered
//   lb_wrbank                  bank written by the renderers
//   busy                       a line is in flight
//   line_done                  line finished without overrun
//   overrun_count              saturating overrun count
module line_render_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_render_start,
  input  logic [8:0] line_idx,
  input  logic       layer0_enabled,
  input  logic       layer1_enabled,
  input  logic       sprites_enabled,
  input  logic       sprite_lb_erase_start,
  input  logic       erase_done,
  input  logic       layer0_done,
  input  logic       layer1_done,
  input  logic       sprite_done,
  input  logic       overrun_clear,
  output logic       layer0_start,
  output logic       layer1_start,
  output logic       sprite_start,
  output logic       render_abort,
  output logic [8:0] render_line,
  output logic       lb_wrbank,
  output logic       busy,
  output logic       line_done,
  output logic [7:0] overrun_count
);

  typedef enum logic [2:0] {
    IDLE,
    L0,
    L1,
    SPR_WAIT,
    SPR
  } state_t;

  state_t state;
  state_t state_nx;

  logic en0;
  logic en1;
  logic ensp;
  logic erase_pending;

  logic pend_eff;
  logic ovr;

  logic l0_nx;
  logic l1_nx;
  logic sp_nx;
  logic abort_nx;
  logic done_nx;

  logic adv;
  logic s0;
  logic s1;
  logic ss;
  logic h0;
  logic h1;
  logic hs;
  logic hn;

  // Pending-erase view including this cycle's pulses,
  // so an erase_done lets the sprite start next cycle.
  assign pend_eff = sprite_lb_erase_start |
                    (erase_pending & ~erase_done);

  assign ovr = line_render_start & (state != IDLE);

  // One-hot pick of the first enabled remaining stage.
  assign h0 = s0;
  assign h1 = s1 & ~s0;
  assign hs = ss & ~s0 & ~s1;
  assign hn = ~(s0 | s1 | ss);

  always_comb begin
    state_nx = state;
    l0_nx    = 1'b0;
    l1_nx    = 1'b0;
    sp_nx    = 1'b0;
    abort_nx = 1'b0;
    done_nx  = 1'b0;
    adv      = 1'b0;
    s0       = 1'b0;
    s1       = 1'b0;
    ss       = 1'b0;

    // A new request overrides any done pulse.
    if (line_render_start) begin
      adv      = 1'b1;
      abort_nx = ovr;
      s0       = layer0_enabled;
      s1       = layer1_enabled;
      ss       = sprites_enabled;
    end else begin
      unique case (state)
        L0: begin
          if (layer0_done) begin
            adv = 1'b1;
            s1  = en1;
            ss  = ensp;
          end
        end
        L1: begin
          if (layer1_done) begin
            adv = 1'b1;
            ss  = ensp;
          end
        end
        SPR_WAIT: begin
          if (!pend_eff) begin
            state_nx = SPR;
            sp_nx    = 1'b1;
          end
        end
        SPR: begin
          if (sprite_done) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (adv) begin
      unique case (1'b1)
        h0: begin
          state_nx = L0;
          l0_nx    = 1'b1;
        end
        h1: begin
          state_nx = L1;
          l1_nx    = 1'b1;
        end
        hs: begin
          if (pend_eff) begin
            state_nx = SPR_WAIT;
          end else begin
            state_nx = SPR;
            sp_nx    = 1'b1;
          end
        end
        hn: begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      en0           <= 1'b0;
      en1           <= 1'b0;
      ensp          <= 1'b0;
      erase_pending <= 1'b0;
      layer0_start  <= 1'b0;
      layer1_start  <= 1'b0;
      sprite_start  <= 1'b0;
      render_abort  <= 1'b0;
      line_done     <= 1'b0;
      render_line   <= 9'd0;
      lb_wrbank     <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      state         <= state_nx;
      busy          <= (state_nx != IDLE);
      erase_pending <= pend_eff;
      layer0_start  <= l0_nx;
      layer1_start  <= l1_nx;
      sprite_start  <= sp_nx;
      render_abort  <= abort_nx;
      line_done     <= done_nx;
      if (line_render_start) begin
        render_line <= line_idx;
        en0         <= layer0_enabled;
        en1         <= layer1_enabled;
        ensp        <= sprites_enabled;
        lb_wrbank   <= ~lb_wrbank;
      end
      if (overrun_clear) begin
        overrun_count <= {7'd0, ovr};
      end else if (ovr && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_render_scheduler.sv
// tb_line_render_scheduler: directed plus random stimulus
// against a stage-list reference model with a scoreboard.
module tb_line_render_scheduler;

  logic       clk;
  logic       rst_n;
  logic       line_render_start;
  logic [8:0] line_idx;
  logic       layer0_enabled;
  logic       layer1_enabled;
  logic       sprites_enabled;
  logic       sprite_lb_erase_start;
  logic       erase_done;
  logic       layer0_done;
  logic       layer1_done;
  logic       sprite_done;
  logic       overrun_clear;
  logic       layer0_start;
  logic       layer1_start;
  logic       sprite_start;
  logic       render_abort;
  logic [8:0] render_line;
  logic       lb_wrbank;
  logic       busy;
  logic       line_done;
  logic [7:0] overrun_count;

  line_render_scheduler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .line_render_start     (line_render_start),
    .line_idx              (line_idx),
    .layer0_enabled        (layer0_enabled),
    .layer1_enabled        (layer1_enabled),
    .sprites_enabled       (sprites_enabled),
    .sprite_lb_erase_start (sprite_lb_erase_start),
    .erase_done            (erase_done),
    .layer0_done           (layer0_done),
    .layer1_done           (layer1_done),
    .sprite_done           (sprite_done),
    .overrun_clear         (overrun_clear),
    .layer0_start          (layer0_start),
    .layer1_start          (layer1_start),
    .sprite_start          (sprite_start),
    .render_abort          (render_abort),
    .render_line           (render_line),
    .lb_wrbank             (lb_wrbank),
    .busy                  (busy),
    .line_done             (line_done),
    .overrun_count         (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a line is a list of stages still to run
  // (0 = layer0, 1 = layer1, 2 = sprite).
  bit       m_act;
  bit       m_started;
  bit       m_pend;
  bit       m_bank;
  logic [8:0] m_line;
  int       m_cnt;
  int       m_stg[$];

  function automatic logic [23:0] pack(
    input bit a, b, c, d, e, f, g,
    input logic [8:0] ln, input int cnt);
    return {a, b, c, d, e, f, g, ln, 8'(cnt)};
  endfunction

  function automatic logic [23:0] act_vec();
    return {layer0_start, layer1_start, sprite_start,
            render_abort, line_done, busy, lb_wrbank,
            render_line, overrun_count};
  endfunction

  task automatic model_reset();
    m_act = 0;
    m_started = 0;
    m_pend = 0;
    m_bank = 0;
    m_line = '0;
    m_cnt = 0;
    m_stg.delete();
  endtask

  task automatic step(
    input bit st, input logic [8:0] idx, input logic [2:0] en,
    input bit ers, ed, d0, d1, ds, clr);
    bit s0, s1, ss, ab, ld, ovr, pn, launch;
    exp_t e;
    s0 = 0; s1 = 0; ss = 0; ab = 0; ld = 0; launch = 0;
    pn = ers ? 1'b1 : (ed ? 1'b0 : m_pend);
    ovr = st && m_act;
    if (st) begin
      ab = ovr;
      m_bank = ~m_bank;
      m_line = idx;
      m_stg.delete();
      if (en[0]) m_stg.push_back(0);
      if (en[1]) m_stg.push_back(1);
      if (en[2]) m_stg.push_back(2);
      m_act = 1;
      m_started = 0;
      launch = 1;
    end else if (m_act) begin
      if (!m_started) begin
        launch = 1;
      end else if ((m_stg[0] == 0 && d0) ||
                   (m_stg[0] == 1 && d1) ||
                   (m_stg[0] == 2 && ds)) begin
        void'(m_stg.pop_front());
        m_started = 0;
        launch = 1;
      end
    end
    if (launch) begin
      if (m_stg.size() == 0) begin
        m_act = 0;
        ld = 1;
      end else if (!(m_stg[0] == 2 && pn)) begin
        m_started = 1;
        if (m_stg[0] == 0) s0 = 1;
        if (m_stg[0] == 1) s1 = 1;
        if (m_stg[0] == 2) ss = 1;
      end
    end
    if (clr) m_cnt = ovr ? 1 : 0;
    else if (ovr && m_cnt < 255) m_cnt = m_cnt + 1;
    m_pend = pn;
    e.cyc = cyc + 1;
    e.v = pack(s0, s1, ss, ab, ld, m_act, m_bank, m_line, m_cnt);
    q.push_back(e);
  endtask

  task automatic tick(
    input bit st, input logic [8:0] idx, input logic [2:0] en,
    input bit ers, ed, d0, d1, ds, clr);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    line_render_start = st;
    line_idx = idx;
    {sprites_enabled, layer1_enabled, layer0_enabled} = en;
    sprite_lb_erase_start = ers;
    erase_done = ed;
    layer0_done = d0;
    layer1_done = d1;
    sprite_done = ds;
    overrun_clear = clr;
    step(st, idx, en, ers, ed, d0, d1, ds, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset away from the clock edge; outputs must be
  // zero in this same cycle, so the pending record is replaced.
  task automatic rst_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    line_render_start = 0;
    sprite_lb_erase_start = 0;
    erase_done = 0;
    layer0_done = 0;
    layer1_done = 0;
    sprite_done = 0;
    overrun_clear = 0;
    if (q.size() > 0 && q[$].cyc == cyc) void'(q.pop_back());
    model_reset();
    e.v = '0;
    e.cyc = cyc;
    q.push_back(e);
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL stale_rec cyc=%0d expected at %0d", cyc, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (act_vec() !== e.v) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d actual=%h required=%h",
                   cyc, act_vec(), e.v);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] en;
    bit st;
    rst_n = 1'b0;
    line_render_start = 0;
    line_idx = '0;
    layer0_enabled = 0;
    layer1_enabled = 0;
    sprites_enabled = 0;
    sprite_lb_erase_start = 0;
    erase_done = 0;
    layer0_done = 0;
    layer1_done = 0;
    sprite_done = 0;
    overrun_clear = 0;
    model_reset();
    rst_cycle();
    rst_cycle();

    // All enabled, erase already finished.
    idle(3);
    tick(1, 9'h05A, 3'b111, 0, 0, 0, 0, 0, 0);
    idle(9);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 0, 0);
    idle(9);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 1, 0, 0);
    idle(9);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Only layer1; stray done pulses ignored.
    tick(1, 9'h101, 3'b010, 0, 0, 0, 0, 0, 0);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 1, 0);
    idle(2);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 1, 0, 0);
    idle(2);

    // All disabled line.
    tick(1, 9'h1FF, 3'b000, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Sprite erase gating.
    tick(0, 9'd0, 3'b000, 1, 0, 0, 0, 0, 0);
    tick(1, 9'h033, 3'b100, 0, 0, 0, 0, 0, 0);
    idle(5);
    tick(0, 9'd0, 3'b000, 0, 1, 0, 0, 0, 0);
    idle(3);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Set and clear in the same cycle: set wins.
    tick(1, 9'h044, 3'b110, 1, 1, 0, 0, 0, 0);
    idle(2);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 1, 0, 0);
    idle(3);
    tick(0, 9'd0, 3'b000, 0, 1, 0, 0, 0, 0);
    idle(2);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Overrun while in L1, with a coincident done.
    tick(1, 9'h010, 3'b111, 0, 0, 0, 0, 0, 0);
    idle(3);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 0, 0);
    idle(3);
    tick(1, 9'h011, 3'b111, 0, 0, 0, 1, 0, 0);
    idle(3);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 0, 0);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 1, 0, 0);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Saturation, then clear coinciding with an overrun.
    for (int i = 0; i < 302; i++)
      tick(1, 9'(i), 3'b111, 0, 0, 0, 0, 0, 0);
    tick(1, 9'h0AA, 3'b001, 0, 0, 0, 0, 0, 1);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 0, 1);
    idle(2);

    // Reset mid-line, then a clean full line.
    tick(1, 9'h077, 3'b111, 0, 0, 0, 0, 0, 0);
    idle(2);
    rst_cycle();
    tick(1, 9'h05A, 3'b111, 0, 0, 0, 0, 0, 0);
    idle(4);
    tick(0, 9'd0, 3'b000, 0, 0, 1, 0, 0, 0);
    idle(4);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 1, 0, 0);
    idle(4);
    tick(0, 9'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Random traffic; enables also wiggle mid-line.
    for (int i = 0; i < 3000; i++) begin
      if (m_act) st = ($urandom_range(0, 39) == 0);
      else       st = ($urandom_range(0, 5) == 0);
      en = 3'($urandom_range(0, 7));
      if (st && m_act && en == 3'b000)
        en = 3'($urandom_range(1, 7));
      tick(st, 9'($urandom), en,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end

    idle(1);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
